// File: rtl/div_pkg.sv
// Shared constants and state encoding for the EX-stage multi-cycle divider.
package div_pkg;

  localparam int DivDataW = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic RstEna            = 1'b1;
  localparam logic Stop              = 1'b1;

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
interface div_if #(
  parameter int DATA_W = 32
) ();

  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/div.sv
// Restoring DIV/DIVU unit: one quotient bit per cycle, holds the pipeline
// via stallreq_o until {remainder, quotient} is valid.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = DivDataW
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  div_state_e            state;
  logic [CNT_W-1:0]      cnt;
  logic [2*DATA_W:0]     work;
  logic [DATA_W-1:0]     divisor;
  logic                  sign1;
  logic                  sign2;
  logic                  signed_op;
  logic [2*DATA_W-1:0]   result;
  logic                  ready;

  logic                  go;
  logic [DATA_W-1:0]     abs1;
  logic [DATA_W-1:0]     abs2;
  logic [2*DATA_W:0]     shifted;
  logic [DATA_W+1:0]     diff;
  logic [2*DATA_W:0]     stepped;
  logic [DATA_W-1:0]     quot;
  logic [DATA_W-1:0]     rem;
  logic [DATA_W-1:0]     fix_q;
  logic [DATA_W-1:0]     fix_r;

  assign go   = (bus.start_i == DivStart) & ~bus.annul_i;
  assign abs1 = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign abs2 = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;

  // Partial remainder lives in the upper half; a borrow out of diff means the
  // trial subtraction failed and the shifted value is kept unchanged.
  assign shifted = work << 1;
  assign diff    = {1'b0, shifted[2*DATA_W:DATA_W]} - {2'b00, divisor};
  assign stepped = diff[DATA_W+1] ? shifted
                                  : {diff[DATA_W:0], shifted[DATA_W-1:1], 1'b1};

  assign quot  = work[DATA_W-1:0];
  assign rem   = work[2*DATA_W-1:DATA_W];
  assign fix_q = (signed_op && (sign1 ^ sign2)) ? -quot : quot;
  assign fix_r = (signed_op && sign1) ? -rem : rem;

  assign bus.result_o   = result;
  assign bus.ready_o    = ready;
  assign bus.stallreq_o = bus.start_i & ~bus.annul_i & ~ready;

  always_ff @(posedge clk) begin
    if (rst == RstEna) begin
      state     <= DivFree;
      cnt       <= '0;
      work      <= '0;
      divisor   <= '0;
      sign1     <= 1'b0;
      sign2     <= 1'b0;
      signed_op <= 1'b0;
      result    <= '0;
      ready     <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          ready  <= DivResultNotReady;
          result <= '0;
          cnt    <= '0;
          if (go && bus.opdata2_i == '0) begin
            state <= DivByZero;
          end else if (go) begin
            state     <= DivOn;
            divisor   <= abs2;
            sign1     <= bus.opdata1_i[DATA_W-1];
            sign2     <= bus.opdata2_i[DATA_W-1];
            signed_op <= bus.signed_div_i;
            work      <= {{(DATA_W+1){1'b0}}, abs1};
          end
        end
        DivByZero: begin
          result <= '0;
          if (bus.annul_i) begin
            state <= DivFree;
            cnt   <= '0;
            ready <= DivResultNotReady;
          end else begin
            state <= DivEnd;
            ready <= DivResultReady;
          end
        end
        DivOn: begin
          if (bus.annul_i) begin
            state  <= DivFree;
            cnt    <= '0;
            ready  <= DivResultNotReady;
            result <= '0;
          end else if (cnt != CNT_W'(DATA_W)) begin
            work <= stepped;
            cnt  <= cnt + CNT_W'(1);
          end else begin
            result <= {fix_r, fix_q};
            ready  <= DivResultReady;
            state  <= DivEnd;
          end
        end
        DivEnd: begin
          state  <= DivFree;
          ready  <= DivResultNotReady;
          result <= '0;
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the divider: latency, stall window,
// signed fix-up, divide-by-zero, annul and reset.
module tb_div;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  div_if #(.DATA_W(32)) bus ();

  div #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic applyStimulus(input logic start, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic annul);
    bus.start_i      = start;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = annul;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds start_i until ready_o, counting cycles with stallreq_o high.
  task automatic doDivide(input string tag, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int exp_stalls,
                          input bit scramble);
    int stalls = 0;
    bit seen   = 1'b0;
    applyStimulus(1'b1, sgn, a, b, 1'b0);
    for (int i = 0; i < 80; i++) begin
      #1;
      if (bus.ready_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.stallreq_o === 1'b1) stalls++;
      if (scramble && stalls == 5) applyStimulus(1'b1, ~sgn, ~a, 32'h3, 1'b0);
      tick();
    end
    checkOutput({tag, "/done"}, 64'(seen), 64'd1);
    checkOutput({tag, "/stalls"}, 64'(stalls), 64'(exp_stalls));
    checkOutput({tag, "/result"}, bus.result_o, exp_res);
    checkOutput({tag, "/stall_end"}, 64'(bus.stallreq_o), 64'd0);
    tick();
    checkOutput({tag, "/free_ready"}, 64'(bus.ready_o), 64'd0);
    checkOutput({tag, "/free_result"}, bus.result_o, 64'd0);
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    checkOutput("reset/ready", 64'(bus.ready_o), 64'd0);
    checkOutput("reset/result", bus.result_o, 64'd0);
    checkOutput("reset/stall", 64'(bus.stallreq_o), 64'd0);
    rst = 1'b0;
    tick();

    applyStimulus(1'b1, 1'b0, 32'd100, 32'd7, 1'b1);
    #1;
    checkOutput("annul_free/stall", 64'(bus.stallreq_o), 64'd0);
    tick();
    checkOutput("annul_free/ready", 64'(bus.ready_o), 64'd0);

    doDivide("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();

    doDivide("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, 1'b0);
    doDivide("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 1'b0);
    doDivide("div_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 34, 1'b0);
    doDivide("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 1'b0);
    doDivide("divu_big", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 34, 1'b0);
    doDivide("divu_by1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34, 1'b0);
    doDivide("divu_small", 1'b0, 32'd3, 32'd7, 64'h00000003_00000000, 34, 1'b0);
    doDivide("div_scramble", 1'b1, 32'h80000000, 32'd2, 64'h00000000_C0000000, 34, 1'b1);

    doDivide("b2b_first", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 1'b0);
    doDivide("b2b_second", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, 1'b0);

    doDivide("divu_zero", 1'b0, 32'd5, 32'd0, 64'd0, 2, 1'b0);
    doDivide("div_zero", 1'b1, 32'hFFFFFFF0, 32'd0, 64'd0, 2, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();

    applyStimulus(1'b1, 1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (10) tick();
    applyStimulus(1'b1, 1'b0, 32'd1000, 32'd3, 1'b1);
    #1;
    checkOutput("annul_on/stall", 64'(bus.stallreq_o), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    checkOutput("annul_on/ready", 64'(bus.ready_o), 64'd0);
    checkOutput("annul_on/result", bus.result_o, 64'd0);
    doDivide("after_annul", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 34, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();

    applyStimulus(1'b1, 1'b0, 32'd50, 32'd5, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput("rst_on/ready", 64'(bus.ready_o), 64'd0);
    checkOutput("rst_on/result", bus.result_o, 64'd0);
    checkOutput("rst_on/stall", 64'(bus.stallreq_o), 64'd0);
    rst = 1'b0;
    tick();
    doDivide("after_rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
